// File: rtl/lbdr_pkt_router.sv
// LBDR route compute with packet lock, single-hop deroute and error flags.
// Latency: route/busy/deroute/err are registered, valid one cycle after the flit.
// No backpressure: flit_valid is taken as-is each cycle, the result feeds the switch allocator.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_we, cfg_*       runtime load of routing bits, connectivity, own address, deroute port
//   flit_valid, flit_id flit presence and type (header/body/tail)
//   dst_addr            destination address, used on headers only
//   route               output port vector {L,S,W,E,N}
//   busy, deroute, err  route locked, route came from deroute, one-cycle error pulse
module lbdr_pkt_router #(
  parameter int                       COORD_W    = 2,
  parameter int                       FID_W      = 3,
  parameter logic [FID_W-1:0]         FID_HEADER = 3'b001,
  parameter logic [FID_W-1:0]         FID_BODY   = 3'b010,
  parameter logic [FID_W-1:0]         FID_TAIL   = 3'b100,
  parameter logic [7:0]               RXY_RST    = 8'd60,
  parameter logic [3:0]               CX_RST     = 4'd15,
  parameter logic [2*COORD_W-1:0]     ADDR_RST   = 5,
  parameter logic [1:0]               DR_RST     = 2'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_rxy,
  input  logic [3:0]           cfg_cx,
  input  logic [2*COORD_W-1:0] cfg_addr,
  input  logic [1:0]           cfg_dr,
  input  logic                 flit_valid,
  input  logic [FID_W-1:0]     flit_id,
  input  logic [2*COORD_W-1:0] dst_addr,
  output logic [4:0]           route,
  output logic                 busy,
  output logic                 deroute,
  output logic                 err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t state, state_nxt;

  logic [7:0]           rxy_q;
  logic [3:0]           cx_q;
  logic [2*COORD_W-1:0] addr_q;
  logic [1:0]           dr_q;

  // Configuration registers; a header in the same cycle as cfg_we still
  // sees the old values because the route below reads the registered copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q  <= RXY_RST;
      cx_q   <= CX_RST;
      addr_q <= ADDR_RST;
      dr_q   <= DR_RST;
    end else if (cfg_we) begin
      rxy_q  <= cfg_rxy;
      cx_q   <= cfg_cx;
      addr_q <= cfg_addr;
      dr_q   <= cfg_dr;
    end
  end

  logic [COORD_W-1:0] x_cur, y_cur, x_dst, y_dst;
  assign x_cur = addr_q[COORD_W-1:0];
  assign y_cur = addr_q[2*COORD_W-1:COORD_W];
  assign x_dst = dst_addr[COORD_W-1:0];
  assign y_dst = dst_addr[2*COORD_W-1:COORD_W];

  logic n1, s1, e1, w1;
  assign n1 = y_dst < y_cur;
  assign s1 = y_cur < y_dst;
  assign e1 = x_cur < x_dst;
  assign w1 = x_dst < x_cur;

  // rxy_q bit order: {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
  logic [4:0] min_vec;
  assign min_vec[0] = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0]) | (n1 & w1 & rxy_q[1])) & cx_q[0];
  assign min_vec[1] = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2]) | (e1 & s1 & rxy_q[3])) & cx_q[1];
  assign min_vec[2] = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4]) | (w1 & s1 & rxy_q[5])) & cx_q[2];
  assign min_vec[3] = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6]) | (s1 & w1 & rxy_q[7])) & cx_q[3];
  assign min_vec[4] = ~n1 & ~e1 & ~w1 & ~s1;

  // Deroute only when no minimal port survives; local never falls through
  // here since min_vec[4] is then set.
  logic [3:0] dr_hot, dr_cand;
  assign dr_hot  = 4'b0001 << dr_q;
  assign dr_cand = dr_hot & cx_q;

  logic       min_ok, res_ok, res_dr;
  logic [4:0] res_route;
  assign min_ok    = |min_vec;
  assign res_ok    = min_ok | (|dr_cand);
  assign res_dr    = ~min_ok;
  assign res_route = min_ok ? min_vec : {1'b0, dr_cand};

  logic is_hdr, is_body, is_tail;
  assign is_hdr  = flit_id == FID_HEADER;
  assign is_body = flit_id == FID_BODY;
  assign is_tail = flit_id == FID_TAIL;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flit_valid) begin
      case (state)
        IDLE:   if (is_hdr && res_ok) state_nxt = LOCKED;
        LOCKED: if (is_tail || (is_hdr && !res_ok)) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered outputs
  logic [4:0] route_nxt;
  logic       busy_nxt, deroute_nxt, err_nxt;

  always_comb begin
    route_nxt   = route;
    busy_nxt    = busy;
    deroute_nxt = deroute;
    err_nxt     = 1'b0;
    if (flit_valid) begin
      if (is_hdr) begin
        // A header while locked means the previous tail went missing.
        err_nxt = (state == LOCKED) || !res_ok;
        if (res_ok) begin
          route_nxt   = res_route;
          busy_nxt    = 1'b1;
          deroute_nxt = res_dr;
        end else begin
          route_nxt   = 5'd0;
          busy_nxt    = 1'b0;
          deroute_nxt = 1'b0;
        end
      end else if (is_tail && state == LOCKED) begin
        route_nxt   = 5'd0;
        busy_nxt    = 1'b0;
        deroute_nxt = 1'b0;
      end else if (!(is_body && state == LOCKED)) begin
        err_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      route   <= 5'd0;
      busy    <= 1'b0;
      deroute <= 1'b0;
      err     <= 1'b0;
    end else begin
      route   <= route_nxt;
      busy    <= busy_nxt;
      deroute <= deroute_nxt;
      err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_lbdr_pkt_router.sv
module tb_lbdr_pkt_router;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_rxy = 8'd0;
  logic [3:0] cfg_cx = 4'd0;
  logic [3:0] cfg_addr = 4'd0;
  logic [1:0] cfg_dr = 2'd0;
  logic       flit_valid = 1'b0;
  logic [2:0] flit_id = 3'd0;
  logic [3:0] dst_addr = 4'd0;
  logic [4:0] route;
  logic       busy, deroute, err;

  lbdr_pkt_router dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx),
    .cfg_addr(cfg_addr), .cfg_dr(cfg_dr), .flit_valid(flit_valid), .flit_id(flit_id),
    .dst_addr(dst_addr), .route(route), .busy(busy), .deroute(deroute), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: packet-level view of the router.
  logic [7:0] m_rxy = 8'd60;
  logic [3:0] m_cx = 4'd15;
  logic [3:0] m_addr = 4'd5;
  logic [1:0] m_dr = 2'd0;
  logic       m_locked = 1'b0;
  logic [4:0] m_route = 5'd0;
  logic       m_der = 1'b0;
  logic       m_err = 1'b0;

  // Wanted ports from the quadrant the destination lies in; diagonal
  // quadrants consult the two routing bits for that quadrant.
  function automatic void calc(input logic [3:0] dst, output logic ok,
                               output logic [4:0] rt, output logic df);
    logic [1:0] xc, yc, xd, yd;
    logic n, s, e, w;
    logic [4:0] want;
    xc = m_addr[1:0]; yc = m_addr[3:2];
    xd = dst[1:0];    yd = dst[3:2];
    n = yd < yc; s = yd > yc; e = xd > xc; w = xd < xc;
    want = 5'd0;
    if (!n && !s && !e && !w) want[4] = 1'b1;
    else if (n && e) begin want[0] = m_rxy[0]; want[1] = m_rxy[2]; end
    else if (n && w) begin want[0] = m_rxy[1]; want[2] = m_rxy[4]; end
    else if (s && e) begin want[3] = m_rxy[6]; want[1] = m_rxy[3]; end
    else if (s && w) begin want[3] = m_rxy[7]; want[2] = m_rxy[5]; end
    else begin want[0] = n; want[1] = e; want[2] = w; want[3] = s; end
    want[3:0] = want[3:0] & m_cx;
    rt = 5'd0; ok = 1'b0; df = 1'b0;
    if (want != 5'd0) begin
      rt = want; ok = 1'b1;
    end else if (m_cx[m_dr]) begin
      rt[m_dr] = 1'b1; ok = 1'b1; df = 1'b1;
    end
  endfunction

  // Apply one cycle of stimulus (called just after a negedge or at t=0),
  // advance the model, then check outputs at the following negedge.
  task automatic step(input logic r, input logic we, input logic [7:0] rxy,
                      input logic [3:0] cx, input logic [3:0] addr, input logic [1:0] dr,
                      input logic v, input logic [2:0] id, input logic [3:0] dst);
    logic ok, df;
    logic [4:0] rt;
    rst = r; cfg_we = we; cfg_rxy = rxy; cfg_cx = cx; cfg_addr = addr; cfg_dr = dr;
    flit_valid = v; flit_id = id; dst_addr = dst;
    if (r) begin
      m_rxy = 8'd60; m_cx = 4'd15; m_addr = 4'd5; m_dr = 2'd0;
      m_locked = 1'b0; m_route = 5'd0; m_der = 1'b0; m_err = 1'b0;
    end else begin
      m_err = 1'b0;
      if (v) begin
        calc(dst, ok, rt, df);
        if (id == HDR) begin
          m_err = m_locked || !ok;
          m_locked = ok; m_route = rt; m_der = ok && df;
        end else if (id == TAIL && m_locked) begin
          m_locked = 1'b0; m_route = 5'd0; m_der = 1'b0;
        end else if (!(id == BODY && m_locked)) begin
          m_err = 1'b1;
        end
      end
      if (we) begin
        m_rxy = rxy; m_cx = cx; m_addr = addr; m_dr = dr;
      end
    end
    @(negedge clk);
    chk("route",   {3'b0, route},   {3'b0, m_route});
    chk("busy",    {7'b0, busy},    {7'b0, m_locked});
    chk("deroute", {7'b0, deroute}, {7'b0, m_der});
    chk("err",     {7'b0, err},     {7'b0, m_err});
  endtask

  task automatic flit(input logic [2:0] id, input logic [3:0] dst);
    step(1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 2'd0, 1'b1, id, dst);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'd0, 4'd0, 4'd0, 2'd0, 1'b0, 3'd0, 4'd0);
  endtask

  task automatic cfg(input logic [3:0] cx, input logic [1:0] dr);
    step(1'b0, 1'b1, 8'd60, cx, 4'd5, dr, 1'b0, 3'd0, 4'd0);
  endtask

  initial begin
    logic [2:0] bad_ids [5];
    bad_ids = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};

    step(1'b1, 1'b0, 8'd0, 4'd0, 4'd0, 2'd0, 1'b0, 3'd0, 4'd0);
    chk("reset_route", {3'b0, route}, 8'd0);

    flit(HDR, 4'd6);
    chk("dir_e", {3'b0, route}, 8'b00010);
    flit(TAIL, 4'd0);

    flit(HDR, 4'd2);
    chk("diag_ne_e", {3'b0, route}, 8'b00010);
    flit(BODY, 4'd0);
    idle(); idle();
    flit(TAIL, 4'd0);
    chk("after_tail", {3'b0, route}, 8'd0);

    cfg(4'b1101, 2'd0);
    flit(HDR, 4'd6);
    chk("deroute_n", {3'b0, route}, 8'b00001);
    chk("deroute_flag", {7'b0, deroute}, 8'd1);
    flit(TAIL, 4'd0);

    cfg(4'b0000, 2'd0);
    flit(HDR, 4'd6);
    chk("unroutable_err", {7'b0, err}, 8'd1);
    idle();

    cfg(4'b1111, 2'd0);
    flit(HDR, 4'd5);
    chk("local", {3'b0, route}, 8'b10000);
    flit(TAIL, 4'd0);
    flit(BODY, 4'd0);

    flit(HDR, 4'd6);
    flit(HDR, 4'd4);
    chk("miss_tail_w", {3'b0, route}, 8'b00100);
    step(1'b1, 1'b0, 8'd0, 4'd0, 4'd0, 2'd0, 1'b0, 3'd0, 4'd0);

    // Config and header in the same cycle: the header must use the old values.
    step(1'b0, 1'b1, 8'd60, 4'b1101, 4'd5, 2'd3, 1'b1, HDR, 4'd6);
    flit(TAIL, 4'd0);

    for (int i = 0; i < 3000; i++) begin
      logic r, we, v;
      logic [2:0] id;
      logic [3:0] cx;
      int pick;
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 3) != 0);
      pick = $urandom_range(0, 9);
      if (pick < 4 || pick == 9) id = HDR;
      else if (pick < 6) id = BODY;
      else if (pick < 8) id = TAIL;
      else id = bad_ids[$urandom_range(0, 4)];
      cx = ($urandom_range(0, 1) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
      step(r, we, 8'($urandom_range(0, 255)), cx, 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)), v, id, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lbdr_pkt_router.md
Name: lbdr_pkt_router

Overview:
- Parametrised successor of the minimal LBDR route-compute unit.
- Sits at one router input port and computes the output-port vector for the packet, from mesh coordinates of any width and runtime-loadable routing, connectivity and deroute registers.
- Adds behaviour the minimal unit lacks: a packet state machine that locks the route from HEADER to TAIL, a single-hop deroute when the minimal path is disconnected, and error/status flags.
- Output is registered; it drives the switch allocator.

Parameters:
- COORD_W, 2, width of each of the X and Y coordinates. Address width is 2*COORD_W, with X in [COORD_W-1:0] and Y in [2*COORD_W-1:COORD_W].
- FID_W, 3, flit_id width.
- FID_HEADER, 3'b001, header flit code.
- FID_BODY, 3'b010, body flit code.
- FID_TAIL, 3'b100, tail flit code.
- RXY_RST, 8'd60, reset value of the routing bits.
- CX_RST, 4'd15, reset value of the connectivity bits.
- ADDR_RST, 5, reset value of the current address.
- DR_RST, 2'd0, reset value of the deroute port code.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  load configuration this cycle.
- cfg_rxy  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, bit 0 = Rne.
- cfg_cx  in  4  connectivity bits {Cs,Cw,Ce,Cn}, bit 0 = Cn.
- cfg_addr  in  2*COORD_W  current router address.
- cfg_dr  in  2  deroute port code: 0=N, 1=E, 2=W, 3=S.
- flit_valid  in  1  flit present (the inverse of FIFO empty).
- flit_id  in  FID_W  flit type.
- dst_addr  in  2*COORD_W  destination address; sampled only on a header.
- route  out  5  port vector, bit 0=N, 1=E, 2=W, 3=S, 4=L.
- busy  out  1  route is locked to a packet.
- deroute  out  1  current route was taken by deroute.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset: the rst cycle loads the configuration registers with the *_RST parameters. All outputs are 0 and the state is IDLE.
- Config:
  - When cfg_we=1, all four configuration registers load at the clock edge.
  - The new values apply to headers arriving in later cycles.
  - An already locked route is not changed.
  - cfg_we together with a header in the same cycle: the header uses the old values.
- Comparators, all unsigned on the coordinates:
  - N1 = y_dst < y_cur
  - S1 = y_cur < y_dst
  - E1 = x_cur < x_dst
  - W1 = x_dst < x_cur
- Minimal vector m:
  - m.N = ((N1&~E1&~W1) | (N1&E1&Rne) | (N1&W1&Rnw)) & Cn
  - m.E = ((E1&~N1&~S1) | (E1&N1&Ren) | (E1&S1&Res)) & Ce
  - m.W = ((W1&~N1&~S1) | (W1&N1&Rwn) | (W1&S1&Rws)) & Cw
  - m.S = ((S1&~E1&~W1) | (S1&E1&Rse) | (S1&W1&Rsw)) & Cs
  - m.L = ~N1 & ~E1 & ~W1 & ~S1
- Deroute:
  - Applies when m==0, i.e. the destination is not local and every minimal port is blocked.
  - Candidate = one-hot(dr) & Cx.
  - If the candidate is non-zero: route = candidate and deroute=1.
  - Otherwise the header is unroutable: err=1, route=0, state stays IDLE.
- State IDLE:
  - flit_valid & HEADER with a routable result: next cycle route = result, busy=1, state -> LOCKED. Latency is 1 cycle.
  - flit_valid & BODY/TAIL/unknown id: err=1, route stays 0.
  - flit_valid=0: nothing changes.
- State LOCKED:
  - route, busy and deroute hold, including while flit_valid=0.
  - flit_valid & BODY: no change.
  - flit_valid & TAIL: next cycle route=0, busy=0, deroute=0, state -> IDLE. The route is therefore visible through the tail's accept cycle.
  - flit_valid & HEADER (missing tail): err=1 and the new header is routed as in IDLE. State stays LOCKED, or goes to IDLE if the new header is unroutable.
  - Unknown id: err=1, state held.
- err asserts for exactly the cycle after the offending flit. It never asserts while flit_valid=0.
- rst asserted mid-packet: the next cycle is IDLE with all outputs 0 and the configuration back at the *_RST defaults.
- At most one bit of route is set unless Rxy enables two minimal ports. Multicast forks are out of scope.

Test Plan:
- After reset with defaults (cur=5, i.e. x=1, y=1; Rxy=60; Cx=15), header dst=6 -> next cycle route=5'b00010 (E), busy=1, deroute=0.
- Header dst=2 (x=2, y=0; Rne=0, Ren=1) -> route=E. Then BODY, a 2-cycle flit_valid gap, and TAIL -> route stays E through the tail cycle, then route=0 and busy=0.
- cfg_we with Cx=4'b1101 (Ce=0) and dr=0, then header dst=6 -> route=N, deroute=1.
- Cx=4'b0000, then header dst=6 -> err pulse for 1 cycle, route=0, busy=0.
- Header dst=5 -> route=L (5'b10000). BODY while IDLE -> err=1, route=0.
- Header dst=6, then header dst=4 with no tail -> err=1 and route=W. rst in the next cycle -> all outputs 0.
